// File: rtl/frame_readout.sv
// Streams a WIDTH x HEIGHT RGB555 frame from BRAM as RGB565 AXI4-Stream video.
// A 3-entry FIFO with read credit hides the one-cycle BRAM latency and absorbs tready stalls.
module frame_readout #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              readout_rst_n,
  input  logic              enable,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              bram_en,
  input  logic [14:0]       bram_data,
  output logic [15:0]       tdata,
  output logic              tvalid,
  input  logic              tready,
  output logic              tlast,
  output logic              tuser,
  output logic              busy,
  output logic              frame_done
);

  localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(HEIGHT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic              r_inflight;
  logic [14:0]       r_mem [3];
  logic [1:0]        r_wptr;
  logic [1:0]        r_rptr;
  logic [1:0]        r_count;
  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;

  logic        w_issue;
  logic        w_push;
  logic        w_pop;
  logic        w_last_beat;
  logic [14:0] w_head;

  // Credit counts both queued words and the word still coming back from BRAM.
  assign w_issue     = (r_state == S_READ) &&
                       (({1'b0, r_count} + {2'b00, r_inflight}) < 3'd3);
  assign w_push      = r_inflight;
  assign w_pop       = (r_count != 2'd0) && tready;
  assign w_last_beat = w_pop && (r_col == LAST_COL) && (r_row == LAST_ROW);
  assign w_head      = r_mem[r_rptr];

  // With enable still high at the end of a frame the next frame begins straight
  // from DRAIN, leaving exactly two idle tvalid cycles between frames.
  always_ff @(posedge clk or negedge readout_rst_n) begin
    if (!readout_rst_n) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (enable) begin
            r_state <= S_READ;
            r_addr  <= '0;
          end
        end
        S_READ: begin
          if (w_issue) begin
            if (r_addr == LAST_ADDR) begin
              r_state <= S_DRAIN;
            end else begin
              r_addr <= r_addr + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (w_last_beat) begin
            if (enable) begin
              r_state <= S_READ;
              r_addr  <= '0;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge readout_rst_n) begin
    if (!readout_rst_n) begin
      r_inflight <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_push) begin
        r_wptr <= (r_wptr == 2'd2) ? 2'd0 : r_wptr + 2'd1;
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == 2'd2) ? 2'd0 : r_rptr + 2'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: tdata is gated by tvalid, which follows r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= bram_data;
    end
  end

  always_ff @(posedge clk or negedge readout_rst_n) begin
    if (!readout_rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_pop) begin
      if (r_col == LAST_COL) begin
        r_col <= '0;
        r_row <= (r_row == LAST_ROW) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  assign tvalid     = (r_count != 2'd0);
  assign tdata      = tvalid ? {w_head[14:10], w_head[9:5], w_head[9], w_head[4:0]} : 16'd0;
  assign tuser      = tvalid && (r_col == '0) && (r_row == '0);
  assign tlast      = tvalid && (r_col == LAST_COL);
  assign bram_en    = w_issue;
  assign bram_addr  = r_addr;
  assign busy       = (r_state != S_IDLE);
  assign frame_done = (r_state == S_DRAIN) && w_last_beat;

endmodule
